// File: rtl/add_subt_responder.sv
// add_subt_responder: handshaked W-bit saturating adder/subtractor.
// A 5-state FSM (IDLE, LOAD, EXEC, SAT, READY) captures the operands, forms an
// exact W+1-bit sum, clamps it to the signed W-bit range, and holds the result
// until the initiator acknowledges it.
module add_subt_responder #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         beg_add_subt,
   input  logic         ack_add_subt,
   input  logic         add_subt,
   input  logic [W-1:0] Data_X,
   input  logic [W-1:0] Data_Y,
   output logic         ready_add_subt,
   output logic         busy,
   output logic [W-1:0] result_out,
   output logic         overflow_flag,
   output logic         underflow_flag
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_SAT   = 3'd3,
      ST_READY = 3'd4
   } state_t;

   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   state_t         r_state;
   state_t         w_next_state;
   logic           r_ready;
   logic [W-1:0]   r_x;
   logic [W-1:0]   r_y;
   logic           r_op;
   logic [W:0]     r_sum;
   logic [W-1:0]   r_result;
   logic           r_ovf;
   logic           r_udf;

   logic [W:0]     w_x_ext;
   logic [W:0]     w_y_opnd;
   logic [W:0]     w_sum;
   logic           w_pos_sat;
   logic           w_neg_sat;

   // State register; reset forces IDLE immediately.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking (=) here would create order-dependent races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state decode; unused encodings fall back to IDLE.
   // NOTE: w_next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_next_state = beg_add_subt ? ST_LOAD : ST_IDLE;
         ST_LOAD:  w_next_state = ST_EXEC;
         ST_EXEC:  w_next_state = ST_SAT;
         ST_SAT:   w_next_state = ST_READY;
         // Only an ack seen while ready is already presented releases READY.
         ST_READY: w_next_state = (ack_add_subt && r_ready) ? ST_IDLE : ST_READY;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Exact W+1-bit datapath: subtraction is X + ~Y + 1 on sign-extended
   // operands, so Y = -2^(W-1) cannot overflow an intermediate.
   assign w_x_ext   = {r_x[W-1], r_x};
   assign w_y_opnd  = r_op ? ~{r_y[W-1], r_y} : {r_y[W-1], r_y};
   assign w_sum     = w_x_ext + w_y_opnd + {{W{1'b0}}, r_op};

   // Saturation detection: the two top bits of the exact sum disagree.
   assign w_pos_sat = ~r_sum[W] &  r_sum[W-1];
   assign w_neg_sat =  r_sum[W] & ~r_sum[W-1];

   // Operand capture in LOAD and sum register in EXEC; held otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x   <= '0;
         r_y   <= '0;
         r_op  <= 1'b0;
         r_sum <= '0;
      end else begin
         if (r_state == ST_LOAD) begin
            r_x  <= Data_X;
            r_y  <= Data_Y;
            r_op <= add_subt;
         end
         if (r_state == ST_EXEC) r_sum <= w_sum;
      end
   end

   // Result and flags change only in SAT and persist across IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (r_state == ST_SAT) begin
         r_ovf <= w_pos_sat;
         r_udf <= w_neg_sat;
         if (w_pos_sat)      r_result <= SAT_MAX;
         else if (w_neg_sat) r_result <= SAT_MIN;
         else                r_result <= r_sum[W-1:0];
      end
   end

   // Registered ready: rises on the first READY cycle (four edges after beg
   // was sampled) and drops on the edge that samples ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_ready <= 1'b0;
      else       r_ready <= (r_state == ST_READY) && !(ack_add_subt && r_ready);
   end

   assign ready_add_subt = r_ready;
   assign busy           = (r_state != ST_IDLE);
   assign result_out     = r_result;
   assign overflow_flag  = r_ovf;
   assign underflow_flag = r_udf;

endmodule

// File: tb/tb_add_subt_responder.sv
// Scoreboard bench for add_subt_responder: the driver pushes hand-computed
// expected results; a monitor pops and compares on each rising ready.
module tb_add_subt_responder;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] result;
      logic         ovf;
      logic         udf;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         beg_add_subt;
   logic         ack_add_subt;
   logic         add_subt;
   logic [W-1:0] Data_X;
   logic [W-1:0] Data_Y;
   logic         ready_add_subt;
   logic         busy;
   logic [W-1:0] result_out;
   logic         overflow_flag;
   logic         underflow_flag;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic prev_ready = 1'b0;
   exp_t last_exp = '0;

   add_subt_responder #(.W(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .beg_add_subt   (beg_add_subt),
      .ack_add_subt   (ack_add_subt),
      .add_subt       (add_subt),
      .Data_X         (Data_X),
      .Data_Y         (Data_Y),
      .ready_add_subt (ready_add_subt),
      .busy           (busy),
      .result_out     (result_out),
      .overflow_flag  (overflow_flag),
      .underflow_flag (underflow_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every rising edge of ready must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (ready_add_subt && !prev_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ready: got result 0x%0h with no transaction pending", result_out);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("result", 64'(result_out), 64'(e.result));
               check("overflow", 64'(overflow_flag), 64'(e.ovf));
               check("underflow", 64'(underflow_flag), 64'(e.udf));
            end
         end
         prev_ready = ready_add_subt;
      end
   end

   // One full transaction; data is scrambled from EXEC onward and ack is
   // withheld for ack_delay cycles to prove the result is held.
   task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                          input logic [W-1:0] r, input logic ov, input logic un,
                          input int ack_delay);
      int n;
      exp_t e;
      e.result = r; e.ovf = ov; e.udf = un;
      exp_q.push_back(e);
      last_exp = e;
      Data_X = x; Data_Y = y; add_subt = op; beg_add_subt = 1'b1;
      n = 0;
      while (n < 12) begin
         @(negedge clk);
         n++;
         if (n == 1) check("busy_in_load", 64'(busy), 64'd1);
         if (ready_add_subt) break;
         if (n >= 2) begin
            Data_X = $urandom(); Data_Y = $urandom(); add_subt = ~add_subt;
         end
      end
      if (!ready_add_subt) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got no ready within %0d cycles, expected 4", n);
         beg_add_subt = 1'b0;
         return;
      end
      check("latency_edges", 64'(n - 1), 64'd4);
      beg_add_subt = 1'b0;
      for (int i = 0; i < ack_delay; i++) begin
         Data_X = $urandom(); Data_Y = $urandom();
         @(negedge clk);
         if (ready_add_subt !== 1'b1 || result_out !== r) begin
            n_cmp++; n_err++;
            $display("FAIL hold: got ready=%b result=0x%0h expected ready=1 result=0x%0h",
                     ready_add_subt, result_out, r);
         end
      end
      if (ack_delay > 0) check("held_result", 64'(result_out), 64'(r));
      ack_add_subt = 1'b1;
      @(negedge clk);
      ack_add_subt = 1'b0;
      check("ready_after_ack", 64'(ready_add_subt), 64'd0);
      check("busy_after_ack", 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1; beg_add_subt = 1'b0; ack_add_subt = 1'b0; add_subt = 1'b0;
      Data_X = '0; Data_Y = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(ready_add_subt), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", 64'(result_out), 64'd0);
      check("rst_flags", 64'({overflow_flag, underflow_flag}), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_txn(32'd5,        32'd3,        1'b0, 32'd8,        1'b0, 1'b0, 0);
      run_txn(32'h7FFFFFFF, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 0);
      run_txn(32'h80000000, 32'd1,        1'b1, 32'h80000000, 1'b0, 1'b1, 0);
      run_txn(32'd0,        32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 0);
      run_txn(32'd10,       32'd20,       1'b1, 32'hFFFFFFF6, 1'b0, 1'b0, 10);
      run_txn(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
      run_txn(32'hFFFFFFFF, 32'h80000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 0);
      run_txn(32'h40000000, 32'h3FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 0);

      // Spurious ack in IDLE: nothing starts, result stays.
      ack_add_subt = 1'b1;
      repeat (2) @(negedge clk);
      ack_add_subt = 1'b0;
      check("idle_ack_busy", 64'(busy), 64'd0);
      check("idle_ack_ready", 64'(ready_add_subt), 64'd0);
      check("idle_ack_result", 64'(result_out), 64'(last_exp.result));

      // Reset pulsed in EXEC: outputs clear at once and no ready follows.
      Data_X = 32'd100; Data_Y = 32'd1; add_subt = 1'b0; beg_add_subt = 1'b1;
      repeat (2) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_result", 64'(result_out), 64'd0);
      check("mid_rst_flags", 64'({overflow_flag, underflow_flag, ready_add_subt}), 64'd0);
      beg_add_subt = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_no_busy", 64'(busy), 64'd0);

      // Normal transaction after the abort, then back-to-back pair.
      run_txn(32'd7,        32'd9,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
      run_txn(32'd1000,     32'd24,       1'b0, 32'd1024,     1'b0, 1'b0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
